seq_mult_unit: RTL and testbench

SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

---
 rtl/seq_mult_pkg.sv | 27 ++
 rtl/mag_conv.sv | 20 ++
 rtl/seq_mult_unit.sv | 145 ++++++++++++++
 tb/tb_seq_mult_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and mode encoding for the sequential multiplier
//
// Purpose: mode encoding constants, the controller state enumeration and
//          small mode-decoding helpers used by seq_mult_unit.
// Ports:   none (package).
package seq_mult_pkg;

  localparam logic [1:0] MODE_UMUL = 2'b00;  // unsigned a*b
  localparam logic [1:0] MODE_SMUL = 2'b01;  // signed a*b
  localparam logic [1:0] MODE_USQ  = 2'b10;  // unsigned a*a
  localparam logic [1:0] MODE_SSQ  = 2'b11;  // signed a*a

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic mode_is_signed(input logic [1:0] m);
    return (m == MODE_SMUL) || (m == MODE_SSQ);
  endfunction

  function automatic logic mode_is_square(input logic [1:0] m);
    return (m == MODE_USQ) || (m == MODE_SSQ);
  endfunction

endpackage

// File: rtl/mag_conv.sv
// rtl/mag_conv.sv - parametrised two's-complement conditional negation
//
// Purpose: res = neg ? -val : val (N-bit, wraps modulo 2^N). Used both to
//          take operand magnitudes and to apply the result sign.
// Ports:   val  input  N  value to convert
//          neg  input  1  negate when 1
//          res  output N  converted value
module mag_conv #(
  parameter int N = 4
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);

  // The most negative value maps to itself, which read as unsigned is
  // exactly its magnitude 2^(N-1).
  assign res = neg ? (~val + N'(1)) : val;

endmodule

// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - radix-2 shift-add multiplier, signed/unsigned, product or square
//
// Purpose: accepts one operation in IDLE, runs W shift-add steps on operand
//          magnitudes in BUSY, presents the signed/unsigned 2W-bit result in DONE.
// Ports:   clk        input  1   clock, rising edge
//          rst_n      input  1   asynchronous active-low reset
//          in_valid   input  1   operands and mode presented
//          in_ready   output 1   high in IDLE only
//          a, b       input  W   operands (b ignored in square modes)
//          mode       input  2   00 u a*b, 01 s a*b, 10 u a*a, 11 s a*a
//          out_valid  output 1   high in DONE only
//          out_ready  input  1   consumer takes product
//          product    output 2W  result
//          busy       output 1   high while not IDLE
module seq_mult_unit
  import seq_mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(W + 1);

  state_t           state, state_nxt;
  logic             accept;
  logic             last_step;

  logic             is_signed, is_square;
  logic [W-1:0]     op_b;
  logic [W-1:0]     mag_a, mag_b;

  logic [2*W-1:0]   mcand;     // multiplicand magnitude, shifted left each step
  logic [W-1:0]     mplier;    // multiplier magnitude, consumed LSB first
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_sum;
  logic [2*W-1:0]   res_signed;
  logic [CW-1:0]    count;
  logic             sign;
  logic [2*W-1:0]   product_q;

  assign is_signed = mode_is_signed(mode);
  assign is_square = mode_is_square(mode);
  assign op_b      = is_square ? a : b;

  mag_conv #(.N(W)) u_mag_a (
    .val (a),
    .neg (is_signed & a[W-1]),
    .res (mag_a)
  );

  mag_conv #(.N(W)) u_mag_b (
    .val (op_b),
    .neg (is_signed & op_b[W-1]),
    .res (mag_b)
  );

  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign last_step = (count == CW'(W - 1));

  // Sign is applied to the final sum in the same edge it is written out.
  mag_conv #(.N(2 * W)) u_neg (
    .val (acc_sum),
    .neg (sign),
    .res (res_signed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      sign      <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      mcand  <= {{W{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      count  <= '0;
      sign   <= is_signed & ~is_square & (a[W-1] ^ op_b[W-1]);
    end else if (state == ST_BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last_step) begin
        product_q <= res_signed;
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb/tb_seq_mult_unit.sv - self-checking bench for seq_mult_unit against an arithmetic model
module tb_seq_mult_unit;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_prod;

  seq_mult_unit #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [1:0] m);
    longint xa, yb, p;
    xa = m[0] ? longint'($signed(x)) : longint'(x);
    if (m[1]) yb = xa;
    else      yb = m[0] ? longint'($signed(y)) : longint'(y);
    p = xa * yb;
    return p[2*W-1:0];
  endfunction

  // Called at a negedge with the DUT idle. Issues one op, checks latency,
  // holds DONE for 'hold' cycles, then takes the result.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m,
                        input int hold, input bit toggle, input bit next_valid);
    logic [2*W-1:0] exp;
    int lat;
    exp = ref_mul(x, y, m);
    check("in_ready_idle", in_ready, 1);
    a = x; b = y; mode = m; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 3 * W) begin
      check("busy_high", busy, 1);
      check("prod_hold_busy", product, last_prod);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, W);
    check("out_valid", out_valid, 1);
    check("product", product, exp);
    last_prod = exp;
    for (int k = 0; k < hold; k++) begin
      if (toggle) begin
        in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check("bp_product", product, exp);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    if (next_valid) begin
      a = W'(5); b = W'(5); mode = 2'b00; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("take_out_valid", out_valid, 0);
    check("take_in_ready", in_ready, 1);
    check("take_busy", busy, 0);
    check("prod_hold_idle", product, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0; out_ready = 1'b0;
    last_prod = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd15, 4'd15, 2'b00, 0, 1'b0, 1'b0);   // 0xE1
    run_op(4'h8,  4'h8,  2'b01, 0, 1'b0, 1'b0);   // +64
    run_op(4'hD,  4'd5,  2'b01, 1, 1'b0, 1'b0);   // -15
    run_op(4'd7,  4'h8,  2'b01, 0, 1'b0, 1'b0);   // -56
    run_op(4'hB,  4'h3,  2'b10, 0, 1'b0, 1'b0);   // 121, b ignored
    run_op(4'hB,  4'h6,  2'b11, 0, 1'b0, 1'b0);   // 25
    run_op(4'h8,  4'h1,  2'b11, 0, 1'b0, 1'b0);   // (-8)^2 = 64
    run_op(4'h9,  4'h2,  2'b00, 10, 1'b1, 1'b0);  // backpressure with toggling inputs

    // Result taken while in_valid is high: no accept on that edge.
    run_op(4'h3,  4'h7,  2'b01, 0, 1'b0, 1'b1);
    check("no_accept_on_take", busy, 0);
    run_op(4'd5,  4'd5,  2'b00, 0, 1'b0, 1'b0);   // accepted one cycle later
    run_op(4'd0,  4'd9,  2'b00, 0, 1'b0, 1'b0);   // zero operand
    run_op(4'hC,  4'd0,  2'b01, 0, 1'b0, 1'b0);   // negative * zero, no -0

    // Asynchronous reset two steps into BUSY.
    a = 4'd15; b = 4'd15; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = '0;
    run_op(4'd3, 4'd3, 2'b00, 0, 1'b0, 1'b0);     // 0x09

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
